ame_equation_solver: RTL and testbench



---
 rtl/ame_equation_solver_if.sv | 26 ++
 rtl/ame_equation_solver.sv | 207 ++++++++++++++++++++
 tb/tb_ame_equation_solver.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/ame_equation_solver_if.sv
// Start/result bundle between the AME gradient accumulators and the equation solver.
interface ame_equation_solver_if #(
    parameter int unsigned COMP_DATA_BITS = 64
);
    logic                                   comp_init_i;
    logic                                   affine_param6_i;
    logic [5:0][6:0][COMP_DATA_BITS-1:0]    comp_data_i;
    logic                                   comp_done_o;
    logic [5:0][COMP_DATA_BITS-1:0]         comp_data_o;

    modport master (
        output comp_init_i,
        output affine_param6_i,
        output comp_data_i,
        input  comp_done_o,
        input  comp_data_o
    );

    modport slave (
        input  comp_init_i,
        input  affine_param6_i,
        input  comp_data_i,
        output comp_done_o,
        output comp_data_o
    );
endinterface

// File: rtl/ame_equation_solver.sv
// Fixed-point Gaussian elimination with partial pivoting for the 4/6-parameter affine
// normal equations; one pivot column at a time, then one unknown per cycle of back-substitution.
module ame_equation_solver #(
    parameter int unsigned COMP_DATA_BITS     = 64,
    parameter int unsigned COMP_DATA_IDX_BITS = 3,
    parameter int unsigned FRAC_BITS          = 16
) (
    input logic                  clk_i,
    input logic                  rst_i,
    ame_equation_solver_if.slave bus
);
    localparam int unsigned W        = COMP_DATA_BITS;
    localparam int unsigned IW       = COMP_DATA_IDX_BITS;
    localparam int unsigned DivSteps = (W + 3) / 4;
    localparam int unsigned CntW     = $clog2(DivSteps + 1);
    localparam logic [W-1:0] DivNum  = W'(1) << (3 * FRAC_BITS);

    typedef logic [W-1:0] word_t;
    typedef enum logic [2:0] {StIdle, StLoad, StPivot, StRecip, StElim, StBack, StDone} state_e;

    state_e                state_q, state_d;
    logic [5:0][6:0][W-1:0] a_q, a_d;
    logic [5:0][W-1:0]     recip_q, recip_d;
    logic [5:0][W-1:0]     x_q, x_d;
    logic [5:0][W-1:0]     res_q, res_d;
    logic [IW-1:0]         k_q, k_d;
    logic [IW-1:0]         k0_q, k0_d;
    logic                  piv_neg_q, piv_neg_d;
    word_t                 den_q, den_d;
    word_t                 rem_q, rem_d;
    word_t                 dq_q, dq_d;
    logic [CntW-1:0]       cnt_q, cnt_d;

    word_t                 best, mag, fac, acc, rem_v, dq_v;
    logic [W:0]            trial;
    logic [IW-1:0]         piv;

    // Full double-width signed product, arithmetic shift (floor), truncated back to one word.
    function automatic word_t mul_shr(input word_t x, input word_t y, input int unsigned sh);
        logic signed [2*W-1:0] p;
        p = $signed({{W{x[W-1]}}, x}) * $signed({{W{y[W-1]}}, y});
        p = p >>> sh;
        return p[W-1:0];
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            a_q       <= '0;
            recip_q   <= '0;
            x_q       <= '0;
            res_q     <= '0;
            k_q       <= '0;
            k0_q      <= '0;
            piv_neg_q <= 1'b0;
            den_q     <= '0;
            rem_q     <= '0;
            dq_q      <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            recip_q   <= recip_d;
            x_q       <= x_d;
            res_q     <= res_d;
            k_q       <= k_d;
            k0_q      <= k0_d;
            piv_neg_q <= piv_neg_d;
            den_q     <= den_d;
            rem_q     <= rem_d;
            dq_q      <= dq_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        recip_d   = recip_q;
        x_d       = x_q;
        res_d     = res_q;
        k_d       = k_q;
        k0_d      = k0_q;
        piv_neg_d = piv_neg_q;
        den_d     = den_q;
        rem_d     = rem_q;
        dq_d      = dq_q;
        cnt_d     = cnt_q;
        best      = '0;
        mag       = '0;
        fac       = '0;
        acc       = '0;
        rem_v     = '0;
        dq_v      = '0;
        trial     = '0;
        piv       = k_q;

        // Largest magnitude at or below row k; strict compare keeps the lowest index on ties.
        for (int i = 0; i < 6; i++) begin
            mag = a_q[i][k_q][W-1] ? (~a_q[i][k_q] + 1'b1) : a_q[i][k_q];
            if (IW'(i) >= k_q && mag > best) begin
                best = mag;
                piv  = IW'(i);
            end
        end

        case (state_q)
            StIdle: begin
                if (bus.comp_init_i) begin
                    k0_d = bus.affine_param6_i ? IW'(0) : IW'(2);
                    for (int r = 0; r < 6; r++) begin
                        for (int c = 0; c < 7; c++) begin
                            if (IW'(r) >= k0_d && (IW'(c) >= k0_d || c == 6)) begin
                                a_d[r][c] = bus.comp_data_i[r][c] << FRAC_BITS;
                            end else begin
                                a_d[r][c] = '0;
                            end
                        end
                    end
                    state_d = StLoad;
                end
            end
            StLoad: begin
                k_d     = k0_q;
                x_d     = '0;
                state_d = StPivot;
            end
            StPivot: begin
                a_d[k_q] = a_q[piv];
                a_d[piv] = a_q[k_q];
                if (best == '0) begin
                    res_d   = '0;
                    state_d = StDone;
                end else begin
                    den_d     = best;
                    piv_neg_d = a_q[piv][k_q][W-1];
                    rem_d     = '0;
                    dq_d      = DivNum;
                    cnt_d     = '0;
                    state_d   = StRecip;
                end
            end
            StRecip: begin
                if (cnt_q == CntW'(DivSteps)) begin
                    recip_d[k_q] = piv_neg_q ? -dq_q : dq_q;
                    state_d      = StElim;
                end else begin
                    // Four restoring steps; dq shifts the dividend out and the quotient in.
                    rem_v = rem_q;
                    dq_v  = dq_q;
                    for (int s = 0; s < 4; s++) begin
                        trial = {rem_v, dq_v[W-1]};
                        dq_v  = {dq_v[W-2:0], 1'b0};
                        if (trial >= {1'b0, den_q}) begin
                            trial   = trial - {1'b0, den_q};
                            dq_v[0] = 1'b1;
                        end
                        rem_v = trial[W-1:0];
                    end
                    rem_d = rem_v;
                    dq_d  = dq_v;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StElim: begin
                for (int i = 0; i < 6; i++) begin
                    fac = mul_shr(a_q[i][k_q], recip_q[k_q], 2 * FRAC_BITS);
                    for (int j = 0; j < 7; j++) begin
                        if (IW'(i) > k_q && IW'(j) >= k_q) begin
                            a_d[i][j] = a_q[i][j] - mul_shr(fac, a_q[k_q][j], FRAC_BITS);
                        end
                    end
                end
                if (k_q == IW'(5)) begin
                    state_d = StBack;
                end else begin
                    k_d     = k_q + 1'b1;
                    state_d = StPivot;
                end
            end
            StBack: begin
                acc = a_q[k_q][6];
                for (int j = 0; j < 6; j++) begin
                    if (IW'(j) > k_q) begin
                        acc = acc - mul_shr(a_q[k_q][j], x_q[j], FRAC_BITS);
                    end
                end
                x_d[k_q] = mul_shr(acc, recip_q[k_q], 2 * FRAC_BITS);
                if (k_q == k0_q) begin
                    res_d   = x_d;
                    state_d = StDone;
                end else begin
                    k_d = k_q - 1'b1;
                end
            end
            StDone: begin
                if (!bus.comp_init_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.comp_done_o = (state_q == StDone);
    assign bus.comp_data_o = res_q;
endmodule

// File: tb/tb_ame_equation_solver.sv
// Directed scenarios for ame_equation_solver; a scoreboard queue holds hand-computed results
// that a monitor checks on each rising comp_done_o.
module tb_ame_equation_solver;
    localparam int W = 64;
    typedef logic [5:0][6:0][W-1:0] mat_t;
    typedef logic [5:0][W-1:0]      vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    vec_t   exp_q[$];
    longint tol_q[$];
    string  name_q[$];
    bit     done_prev = 1'b0;

    ame_equation_solver_if #(.COMP_DATA_BITS(W)) bus ();

    ame_equation_solver #(
        .COMP_DATA_BITS(W),
        .COMP_DATA_IDX_BITS(3),
        .FRAC_BITS(16)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input bit ok, input string name, input longint act, input longint req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic bit close(input logic [W-1:0] a, input logic [W-1:0] e, input longint tol);
        longint d;
        d = longint'($signed(a)) - longint'($signed(e));
        return (d <= tol) && (d >= -tol);
    endfunction

    function automatic mat_t set_row(input mat_t m, input int r, input longint a0, input longint a1,
                                     input longint a2, input longint a3, input longint a4,
                                     input longint a5, input longint b);
        m[r][0] = a0; m[r][1] = a1; m[r][2] = a2; m[r][3] = a3;
        m[r][4] = a4; m[r][5] = a5; m[r][6] = b;
        return m;
    endfunction

    function automatic vec_t v6(input longint x0, input longint x1, input longint x2,
                                input longint x3, input longint x4, input longint x5);
        vec_t v;
        v[0] = x0; v[1] = x1; v[2] = x2; v[3] = x3; v[4] = x4; v[5] = x5;
        return v;
    endfunction

    function automatic mat_t garbage();
        mat_t m;
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 7; c++)
                m[r][c] = {$urandom, $urandom};
        return m;
    endfunction

    // Monitor: compare every completion against the oldest scoreboard entry.
    initial begin : monitor
        vec_t   e;
        longint t;
        string  n;
        forever begin
            @(negedge clk);
            if (bus.comp_done_o && !done_prev) begin
                if (exp_q.size() == 0) begin
                    check(1'b0, "unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    t = tol_q.pop_front();
                    n = name_q.pop_front();
                    for (int k = 0; k < 6; k++)
                        check(close(bus.comp_data_o[k], e[k], t), $sformatf("%s_x%0d", n, k),
                              longint'($signed(bus.comp_data_o[k])), longint'($signed(e[k])));
                end
            end
            done_prev = bus.comp_done_o;
        end
    end

    task automatic run_case(input mat_t m, input bit p6, input vec_t ex, input longint tol,
                            input string name, input int hold, input int limit);
        int lat;
        int bad;
        @(negedge clk);
        exp_q.push_back(ex);
        tol_q.push_back(tol);
        name_q.push_back(name);
        bus.comp_data_i     = m;
        bus.affine_param6_i = p6;
        bus.comp_init_i     = 1'b1;
        @(posedge clk);
        #1;
        // Inputs after the sampling edge must not influence this run.
        bus.comp_data_i     = garbage();
        bus.affine_param6_i = ~p6;
        lat = 0;
        while (!bus.comp_done_o && lat < 300) begin
            @(posedge clk);
            lat++;
            #1;
        end
        check(bus.comp_done_o && lat <= limit, {name, "_latency"}, lat, limit);
        bad = 0;
        repeat (hold) begin
            @(negedge clk);
            if (!bus.comp_done_o) bad++;
            for (int k = 0; k < 6; k++)
                if (!close(bus.comp_data_o[k], ex[k], tol)) bad++;
        end
        check(bad == 0, {name, "_hold"}, bad, 0);
        @(negedge clk);
        bus.comp_init_i = 1'b0;
        @(posedge clk);
        #1;
        check(!bus.comp_done_o, {name, "_drop"}, longint'(bus.comp_done_o), 0);
        bad = 0;
        for (int k = 0; k < 6; k++)
            if (!close(bus.comp_data_o[k], ex[k], tol)) bad++;
        check(bad == 0, {name, "_keep"}, bad, 0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        mat_t m_s1, m_diag, m_id, m_sing, m_iso, g;
        vec_t ex_s1, ex_diag, ex_id, ex_zero;
        int   bad;

        m_s1 = '0;
        m_s1 = set_row(m_s1, 2, 0, 0, 0, 1, 2, 2, 1);
        m_s1 = set_row(m_s1, 3, 0, 0, 1, 1, 1, 1, 0);
        m_s1 = set_row(m_s1, 4, 0, 0, 0, -1, -4, -2, 1);
        m_s1 = set_row(m_s1, 5, 0, 0, 3, 2, 1, -1, -1);
        ex_s1 = v6(0, 0, -131072, 196608, -65536, 0);

        m_diag = '0;
        for (int k = 0; k < 6; k++) begin
            m_diag[k][k] = 2;
            m_diag[k][6] = 2 * (k + 1);
        end
        ex_diag = v6(65536, 131072, 196608, 262144, 327680, 393216);

        m_id = '0;
        m_id = set_row(m_id, 2, 0, 0, 1, 0, 0, 0, 3);
        m_id = set_row(m_id, 3, 0, 0, 0, 1, 0, 0, -5);
        m_id = set_row(m_id, 4, 0, 0, 0, 0, 1, 0, 7);
        m_id = set_row(m_id, 5, 0, 0, 0, 0, 0, 1, -1);
        ex_id = v6(0, 0, 196608, -327680, 458752, -65536);

        m_sing = m_s1;
        m_sing = set_row(m_sing, 3, 0, 0, 0, 1, 2, 2, 1);
        ex_zero = '0;

        g = garbage();
        m_iso = m_s1;
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 7; c++)
                if (r < 2 || c < 2) m_iso[r][c] = g[r][c];

        bus.comp_init_i     = 1'b0;
        bus.affine_param6_i = 1'b0;
        bus.comp_data_i     = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check(!bus.comp_done_o, "reset_done", longint'(bus.comp_done_o), 0);
        check(bus.comp_data_o == '0, "reset_data", longint'($signed(bus.comp_data_o[2])), 0);
        @(negedge clk);
        rst = 1'b0;

        run_case(m_s1,   1'b0, ex_s1,   4, "pivot4",    2,   100);
        run_case(m_diag, 1'b1, ex_diag, 0, "diag6",     200, 150);
        run_case(m_id,   1'b0, ex_id,   0, "reraise4",  2,   100);
        run_case(m_sing, 1'b0, ex_zero, 0, "singular4", 2,   100);
        run_case(m_iso,  1'b0, ex_s1,   4, "isolate4",  2,   100);

        // Abort a run while the first column is being eliminated.
        @(negedge clk);
        bus.comp_data_i     = m_s1;
        bus.affine_param6_i = 1'b0;
        bus.comp_init_i     = 1'b1;
        @(posedge clk);
        repeat (19) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check(!bus.comp_done_o, "midreset_done", longint'(bus.comp_done_o), 0);
        bad = 0;
        for (int k = 0; k < 6; k++)
            if (bus.comp_data_o[k] != '0) bad++;
        check(bad == 0, "midreset_data", bad, 0);
        @(negedge clk);
        rst             = 1'b0;
        bus.comp_init_i = 1'b0;
        repeat (2) @(negedge clk);

        run_case(m_s1, 1'b0, ex_s1, 4, "after_reset", 2, 100);

        repeat (3) @(negedge clk);
        check(exp_q.size() == 0, "scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
